// File: rtl/qupls4_copro_ifetch.sv
// Qupls4 coprocessor instruction fetch / prefetch stage.
// Issues reads to a synchronous instruction RAM, buffers the returned words with
// their word PC in a small FIFO and hands them to the execute sequencer over a
// valid/ready handshake. A redirect flushes the FIFO and restarts fetch.
// Optional build macro: COPRO_IFETCH_PERF_EN adds the perf_stall counter output.
module qupls4_copro_ifetch #(
  parameter int                   IMEM_AW  = 10,
  parameter int                   DEPTH    = 4,
  parameter logic [IMEM_AW-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               redirect,
  input  logic [IMEM_AW-1:0] redirect_pc,
  output logic               imem_rd,
  output logic [IMEM_AW-1:0] imem_adr,
  input  logic [31:0]        imem_dat,
  output logic               ins_valid,
  output logic [31:0]        ins,
  output logic [IMEM_AW-1:0] ins_pc,
  input  logic               ins_ready
`ifdef COPRO_IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IMEM_AW-1:0] fetch_pc;
  logic [CW-1:0]      count;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               inflight;
  logic               inflight_tag;
  logic [IMEM_AW-1:0] inflight_pc;
  logic               epoch;
  logic [31:0]        ins_mem [DEPTH];
  logic [IMEM_AW-1:0] pc_mem  [DEPTH];

  logic issue;
  logic wr_en;
  logic pop;
  logic [CW:0] credit_used;

  // Credit check: words held plus the word still in the RAM pipe must leave room.
  // A pop in this cycle is deliberately not counted as freeing a slot.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue       = rst_n & en & ~redirect & (credit_used < (CW+1)'(DEPTH));

  assign imem_rd  = issue;
  assign imem_adr = fetch_pc;

  // A returning word is kept only if it was issued in the current epoch and
  // no redirect is flushing the buffer this cycle.
  assign wr_en = inflight & (inflight_tag == epoch) & ~redirect;

  assign ins_valid = (count != '0);
  assign pop       = ins_valid & ins_ready;
  assign ins       = ins_mem[rd_ptr];
  assign ins_pc    = pc_mem[rd_ptr];

  // Fetch PC, epoch, FIFO pointers/occupancy and the RAM-pipe tracking flop.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc     <= RESET_PC;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      epoch        <= 1'b0;
      inflight     <= 1'b0;
      inflight_tag <= 1'b0;
      inflight_pc  <= '0;
    end else begin
      inflight     <= issue;
      inflight_tag <= epoch;
      inflight_pc  <= fetch_pc;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        epoch    <= ~epoch;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + IMEM_AW'(1);
        if (wr_en) wr_ptr <= wr_ptr + PW'(1);
        if (pop)   rd_ptr <= rd_ptr + PW'(1);
        case ({wr_en, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // FIFO storage: instruction word and its PC written at the tail.
  // NOTE: this tiny array is reset so ins/ins_pc read as zero straight out of reset;
  // large RAMs would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ins_mem[i] <= '0;
        pc_mem[i]  <= '0;
      end
    end else if (wr_en) begin
      ins_mem[wr_ptr] <= imem_dat;
      pc_mem[wr_ptr]  <= inflight_pc;
    end
  end

`ifdef COPRO_IFETCH_PERF_EN
  // Saturating count of cycles where the executor is waiting on fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall <= '0;
    end else if (ins_ready && !ins_valid && !redirect && (perf_stall != 32'hFFFF_FFFF)) begin
      perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  // Performance counter not built in this configuration.
`endif

endmodule
